// File: rtl/auth_link_ctrl.sv
// auth_link_ctrl: 8N1 UART receiver feeding the rider power-authorisation FSM,
// with glitch-filtered start detection, framing-error rejection and a
// link-loss watchdog that drops authorisation when the Bluetooth link goes quiet.
module auth_link_ctrl #(
    parameter int unsigned BAUD_DIV  = 2604,
    parameter logic [7:0]  GO_CODE   = 8'h67,
    parameter logic [7:0]  STOP_CODE = 8'h73,
    parameter int unsigned LINK_TO   = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic [1:0] state,
    output logic       rx_err,
    output logic       link_lost
);

    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned WW = (LINK_TO > 0) ? $clog2(LINK_TO + 1) : 1;
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] FULL_LAST = BW'(BAUD_DIV - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'((LINK_TO > 0) ? LINK_TO - 1 : 0);
    localparam bit            WD_EN     = (LINK_TO > 0);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_t;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        PWR1 = 2'b01,
        PWR2 = 2'b10
    } pwr_state_t;

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    rx_state_t     rx_st;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic          rx_rdy;

    pwr_state_t    pwr_q;
    pwr_state_t    next_c;
    logic [WW-1:0] wd_cnt;
    logic          is_go_c;
    logic          is_stop_c;
    logic          fire_c;

    assign state = pwr_q;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // UART receiver: mid-bit sampling, glitch reject in START, stop-bit check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st    <= RX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_rdy   <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_rdy <= 1'b0;
            rx_err <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (rx_prev && !rx_sync) begin
                        rx_st <= RX_START;
                    end
                end
                RX_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        rx_st    <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        shift    <= {rx_sync, shift[7:1]};
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rx_st <= RX_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        rx_rdy   <= rx_sync;
                        rx_err   <= !rx_sync;
                        rx_st    <= RX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    // Command decode, watchdog fire and power next-state selection
    always_comb begin
        is_go_c   = rx_rdy && (shift == GO_CODE);
        is_stop_c = rx_rdy && (shift == STOP_CODE);
        fire_c    = WD_EN && (pwr_q != OFF) && (wd_cnt == WD_LAST) && !rx_rdy;
        next_c    = pwr_q;
        case (pwr_q)
            OFF: begin
                if (is_go_c) begin
                    next_c = PWR1;
                end
            end
            PWR1: begin
                if (is_stop_c || fire_c) begin
                    next_c = rider_off ? OFF : PWR2;
                end
            end
            PWR2: begin
                if (rider_off) begin
                    next_c = OFF;
                end else if (is_go_c) begin
                    next_c = PWR1;
                end
            end
            default: next_c = OFF;
        endcase
    end

    // Power state, registered outputs and link-loss watchdog counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_q     <= OFF;
            pwr_up    <= 1'b0;
            link_lost <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            pwr_q     <= next_c;
            pwr_up    <= (next_c != OFF);
            link_lost <= fire_c;
            if ((next_c == OFF) || rx_rdy || fire_c || (next_c != pwr_q) || !WD_EN) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_auth_link_ctrl.sv
// Scoreboard bench for auth_link_ctrl: stimulus pushes expected output events,
// a negedge monitor pops and compares every observed output event.
module tb_auth_link_ctrl;

    localparam int BAUD = 16;
    localparam int LTO  = 4000;
    localparam logic [7:0] GO   = 8'h67;
    localparam logic [7:0] STOP = 8'h73;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rider_off = 1'b0;
    logic       pwr_up;
    logic [1:0] state;
    logic       rx_err;
    logic       link_lost;

    auth_link_ctrl #(
        .BAUD_DIV (BAUD),
        .GO_CODE  (GO),
        .STOP_CODE(STOP),
        .LINK_TO  (LTO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (rx),
        .rider_off(rider_off),
        .pwr_up   (pwr_up),
        .state    (state),
        .rx_err   (rx_err),
        .link_lost(link_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] st;
        logic       err;
        logic       ll;
        int         lo;
        int         hi;
        bit         wd;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] ms = 2'd0;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // Reference rules for the power FSM on a valid byte
    function automatic logic [1:0] ref_next(input logic [1:0] s, input logic [7:0] b, input logic ro);
        case (s)
            2'd0:    return (b == GO) ? 2'd1 : 2'd0;
            2'd1:    return (b == STOP) ? (ro ? 2'd0 : 2'd2) : 2'd1;
            default: return ro ? 2'd0 : ((b == GO) ? 2'd1 : 2'd2);
        endcase
    endfunction

    task automatic push(input logic [1:0] st, input logic err, input logic ll,
                        input int lo, input int hi, input bit wd);
        exp_t e;
        e.st = st; e.err = err; e.ll = ll; e.lo = lo; e.hi = hi; e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        int t0;
        logic [1:0] ns;
        logic [7:0] bb;
        t0 = cyc;
        bb = b;
        if (stop_bit) begin
            ns = ref_next(ms, bb, rider_off);
            if (ns != ms) push(ns, 1'b0, 1'b0, t0 + 9 * BAUD, t0 + 10 * BAUD, 1'b0);
            ms = ns;
        end else begin
            push(ms, 1'b1, 1'b0, t0 + 9 * BAUD, t0 + 10 * BAUD, 1'b0);
        end
        rx = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = bb[i];
            tick(BAUD);
        end
        rx = stop_bit;
        tick(BAUD);
        rx = 1'b1;
    endtask

    task automatic set_rider(input logic v);
        rider_off = v;
        if (v && ms == 2'd2) begin
            push(2'd0, 1'b0, 1'b0, cyc + 1, cyc + 1, 1'b0);
            ms = 2'd0;
        end
    endtask

    task automatic go_off();
        set_rider(1'b1);
        if (ms == 2'd1) send_frame(STOP, 1'b1);
        tick(20);
    endtask

    // Monitor: any state change or pulse is an output event to score
    logic [1:0] prev_st = 2'd0;
    int         last_evt = 0;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_st  = 2'd0;
            last_evt = cyc;
        end else if (state != prev_st || rx_err || link_lost) begin
            chk("event_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("state", int'(state), int'(mon_e.st));
                chk("rx_err", int'(rx_err), int'(mon_e.err));
                chk("link_lost", int'(link_lost), int'(mon_e.ll));
                if (mon_e.wd) chk("wd_interval", cyc - last_evt, LTO);
                else chk_range("latency", cyc, mon_e.lo, mon_e.hi);
            end
            chk("pwr_up", int'(pwr_up), int'(state != 2'd0));
            prev_st  = state;
            last_evt = cyc;
        end
    end

    initial begin
        logic [7:0] b;
        logic       stop_ok;
        logic       prev_err;
        int         r;

        tick(3);
        chk("rst_state", int'(state), 0);
        chk("rst_pwr_up", int'(pwr_up), 0);
        chk("rst_rx_err", int'(rx_err), 0);
        chk("rst_link_lost", int'(link_lost), 0);
        rst_n = 1'b1;
        tick(5);

        // GO -> PWR1; STOP with rider off -> OFF
        send_frame(GO, 1'b1);
        tick(20);
        set_rider(1'b1);
        tick(2);
        send_frame(STOP, 1'b1);
        tick(20);

        // Back-to-back GO, STOP with rider on -> PWR2; rider leaves -> OFF
        set_rider(1'b0);
        send_frame(GO, 1'b1);
        send_frame(STOP, 1'b1);
        tick(20);
        set_rider(1'b1);
        tick(5);

        // PWR2 + GO -> PWR1, then back to PWR2, rider leaves, GO while absent
        set_rider(1'b0);
        send_frame(GO, 1'b1);
        send_frame(STOP, 1'b1);
        send_frame(GO, 1'b1);
        send_frame(STOP, 1'b1);
        tick(10);
        set_rider(1'b1);
        tick(3);
        send_frame(GO, 1'b1);
        send_frame(STOP, 1'b1);
        tick(20);

        // Framing error and start-bit glitch
        send_frame(GO, 1'b0);
        tick(BAUD);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * BAUD);

        // Silent link in PWR1, rider on -> link_lost and PWR2
        set_rider(1'b0);
        send_frame(GO, 1'b1);
        push(2'd2, 1'b0, 1'b1, 0, 0, 1'b1);
        ms = 2'd2;
        tick(LTO + 50);
        set_rider(1'b1);
        tick(5);

        // Silent link in PWR1, rider off -> link_lost and OFF
        send_frame(GO, 1'b1);
        push(2'd0, 1'b0, 1'b1, 0, 0, 1'b1);
        ms = 2'd0;
        tick(LTO + 50);

        // Keep-alive bytes every 3000 clocks hold the link
        set_rider(1'b0);
        send_frame(GO, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(3000 - 10 * BAUD);
            send_frame(8'h41, 1'b1);
        end
        tick(100);
        go_off();

        // Randomised byte stream against the reference rules
        prev_err = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) set_rider(1'($urandom_range(0, 1)));
            r = $urandom_range(0, 9);
            b = (r < 4) ? GO : (r < 7) ? STOP : 8'($urandom_range(0, 255));
            stop_ok = prev_err || ($urandom_range(0, 7) != 0);
            prev_err = !stop_ok;
            send_frame(b, stop_ok);
            if (!stop_ok) tick(BAUD);
            tick($urandom_range(0, 30));
        end
        go_off();

        // Reset mid-byte in PWR2, then a clean GO
        set_rider(1'b0);
        send_frame(GO, 1'b1);
        send_frame(STOP, 1'b1);
        tick(20);
        rx = 1'b0;
        tick(BAUD);
        rx = 1'b1;
        tick(3 * BAUD);
        rx = 1'b0;
        tick(2 * BAUD);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_pwr_up", int'(pwr_up), 0);
        chk("arst_rx_err", int'(rx_err), 0);
        chk("arst_link_lost", int'(link_lost), 0);
        ms = 2'd0;
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        send_frame(GO, 1'b1);
        tick(20);
        go_off();

        tick(50);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
